// File: rtl/sa_drain_collector.sv
// Receives per-column result drain chains from a systolic array, buffers each column in a
// first-word-fall-through FIFO and re-serialises the tile as a row-major valid/ready stream.
module sa_drain_collector #(
   parameter int unsigned D_W_ACC = 64,
   parameter int unsigned N       = 4,
   parameter int unsigned ROWS    = 4,
   parameter int unsigned DEPTH   = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [N*D_W_ACC-1:0]                in_data,
   input  logic [N-1:0]                        in_valid,
   output logic [D_W_ACC-1:0]                  out_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_col,
   output logic                                out_last,
   output logic                                overflow
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned PW   = AW + 1;
   localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned TILE = ROWS * N;
   localparam int unsigned WCW  = (TILE > 1) ? $clog2(TILE) : 1;

   logic [D_W_ACC-1:0] mem_q    [N][DEPTH];
   logic [PW-1:0]      wr_ptr_q [N];
   logic [PW-1:0]      rd_ptr_q [N];
   logic [CW-1:0]      sel_q;
   logic [WCW-1:0]     wcnt_q;
   logic               overflow_q;

   logic [N-1:0]       empty;
   logic [N-1:0]       full;
   logic [N-1:0]       push;
   logic [N-1:0]       pop;
   logic [N-1:0]       drop;
   logic               handshake;
   logic [D_W_ACC-1:0] head;

   always_comb begin
      empty = '0;
      full  = '0;
      for (int unsigned c = 0; c < N; c++) begin
         empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
         full[c]  = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                    (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
      end
   end

   // Output only ever looks at the selected column; an empty column stalls the stream.
   always_comb begin
      out_valid = !empty[sel_q];
      head      = mem_q[sel_q][rd_ptr_q[sel_q][AW-1:0]];
      out_data  = out_valid ? head : '0;
      out_col   = sel_q;
      out_last  = out_valid && (wcnt_q == WCW'(TILE - 1));
      overflow  = overflow_q;
      handshake = out_valid && out_ready;
   end

   // A full FIFO still accepts a push when its head is popped in the same cycle.
   always_comb begin
      pop  = '0;
      push = '0;
      drop = '0;
      for (int unsigned c = 0; c < N; c++) begin
         pop[c]  = handshake && (sel_q == CW'(c));
         push[c] = in_valid[c] && (!full[c] || pop[c]);
         drop[c] = in_valid[c] && full[c] && !pop[c];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned c = 0; c < N; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
         end
         sel_q      <= '0;
         wcnt_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         for (int unsigned c = 0; c < N; c++) begin
            if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + PW'(1);
            if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + PW'(1);
         end
         if (handshake) begin
            sel_q  <= (sel_q == CW'(N - 1)) ? '0 : sel_q + CW'(1);
            wcnt_q <= (wcnt_q == WCW'(TILE - 1)) ? '0 : wcnt_q + WCW'(1);
         end
         if (|drop) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned c = 0; c < N; c++) begin
         if (!rst && push[c]) begin
            mem_q[c][wr_ptr_q[c][AW-1:0]] <= in_data[c*D_W_ACC +: D_W_ACC];
         end
      end
   end

endmodule

// File: tb/tb_sa_drain_collector.sv
// Randomised and directed bench for sa_drain_collector, checked every cycle against a
// queue-based model of the per-column buffers and the row-major output order.
module tb_sa_drain_collector;

   localparam int unsigned DW    = 64;
   localparam int unsigned N     = 4;
   localparam int unsigned ROWS  = 4;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned TILE  = ROWS * N;

   logic          clk = 1'b0;
   logic          rst;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]  in_valid;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_col;
   logic          out_last;
   logic          overflow;

   sa_drain_collector #(
      .D_W_ACC (DW),
      .N       (N),
      .ROWS    (ROWS),
      .DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_col   (out_col),
      .out_last  (out_last),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: one queue per column, selected column, word index within tile.
   logic [DW-1:0] mq [N][$];
   int            msel;
   int            mwcnt;
   bit            movf;
   logic [DW-1:0] got [$];
   int            got_col [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < N; c++) mq[c].delete();
      msel  = 0;
      mwcnt = 0;
      movf  = 1'b0;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = N'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = '0;
      model_reset();
   endtask

   // One clock: drive inputs, compare outputs with the model, then advance the model.
   task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic rdy);
      bit            ev;
      bit            hs;
      logic [DW-1:0] ed;
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      ev = (mq[msel].size() != 0);
      ed = ev ? mq[msel][0] : '0;
      check("out_valid", out_valid, ev);
      check("out_data", out_data, ed);
      check("out_col", out_col, msel);
      check("out_last", out_last, ev && (mwcnt == TILE - 1));
      check("overflow", overflow, movf);
      if (out_valid && rdy) begin
         got.push_back(out_data);
         got_col.push_back(int'(out_col));
      end
      hs = ev && rdy;
      for (int c = 0; c < N; c++) begin
         bit pop;
         int sz;
         pop = hs && (c == msel);
         sz  = mq[c].size();
         if (pop) void'(mq[c].pop_front());
         if (v[c]) begin
            if (sz < DEPTH || pop) mq[c].push_back(d[c*DW +: DW]);
            else movf = 1'b1;
         end
      end
      if (hs) begin
         msel  = (msel + 1) % N;
         mwcnt = (mwcnt + 1) % TILE;
      end
      @(posedge clk);
      #1;
   endtask

   // Column c emits 16*r+c for r=0..ROWS-1, starting c cycles after column 0.
   task automatic run_skew(input int ncyc, input bit toggle, input int stop_hs);
      for (int t = 0; t < ncyc; t++) begin
         logic [N-1:0]    v;
         logic [N*DW-1:0] d;
         if (stop_hs > 0 && got.size() >= stop_hs) break;
         v = '0;
         d = '0;
         for (int c = 0; c < N; c++) begin
            if (t - c >= 0 && t - c < ROWS) begin
               v[c]         = 1'b1;
               d[c*DW +: DW] = DW'(16 * (t - c) + c);
            end
         end
         step(v, d, toggle ? (t % 2 == 0) : 1'b1);
      end
   endtask

   task automatic check_tile_seq(input string tag);
      check({tag, "_len"}, got.size(), TILE);
      for (int i = 0; i < TILE && i < got.size(); i++) begin
         check(tag, got[i], 64'(16 * (i / N) + (i % N)));
      end
   endtask

   initial begin
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      do_reset();

      // Single tile, skewed drain, ready high.
      got.delete();
      run_skew(30, 1'b0, 0);
      check_tile_seq("s1_seq");

      // Same tile with out_ready toggling.
      do_reset();
      got.delete();
      run_skew(50, 1'b1, 0);
      check_tile_seq("s2_seq");

      // Wait on empty column 1.
      do_reset();
      got.delete();
      for (int t = 0; t < 12; t++) begin
         logic [N-1:0]    v;
         logic [N*DW-1:0] d;
         v = '0;
         d = '0;
         if (t == 0) begin v[0] = 1'b1; d[0 +: DW] = 64'hA; end
         if (t == 5) begin v[1] = 1'b1; d[DW +: DW] = 64'hB; end
         step(v, d, 1'b1);
      end
      check("s3_len", got.size(), 2);
      if (got.size() == 2) begin
         check("s3_w0", got[0], 64'hA);
         check("s3_w1", got[1], 64'hB);
      end

      // Overflow on column 2, then drain with other columns filled.
      do_reset();
      got.delete();
      got_col.delete();
      for (int i = 0; i < 9; i++) begin
         logic [N*DW-1:0] d;
         d = '0;
         d[2*DW +: DW] = DW'(i);
         step(4'b0100, d, 1'b0);
      end
      check("s4_ovf_set", overflow, 1'b1);
      for (int t = 0; t < 45; t++) begin
         logic [N*DW-1:0] d;
         d = '0;
         for (int c = 0; c < N; c++) d[c*DW +: DW] = DW'(1000 * c + t);
         step((t < 8) ? 4'b1011 : 4'b0000, d, 1'b1);
      end
      begin
         int k;
         k = 0;
         for (int i = 0; i < got.size(); i++) begin
            if (got_col[i] == 2) begin
               check("s4_col2", got[i], 64'(k));
               k++;
            end
         end
         check("s4_col2_cnt", k, 8);
      end
      check("s4_ovf_hold", overflow, 1'b1);

      // Full column 0 with simultaneous pop and push.
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(4'b0001, (N*DW)'(100 + i), 1'b0);
      step(4'b0001, (N*DW)'(200), 1'b1);
      check("s5_ovf", overflow, 1'b0);
      check("s5_col", out_col, 1);

      // Reset mid-tile.
      do_reset();
      got.delete();
      run_skew(30, 1'b0, 6);
      check("s6_pre", got.size(), 6);
      do_reset();
      check("s6_rst_valid", out_valid, 1'b0);
      check("s6_rst_col", out_col, 0);
      got.delete();
      run_skew(30, 1'b0, 0);
      check_tile_seq("s6_seq");

      // Random traffic: light then heavy push rates, occasional resets.
      for (int ph = 0; ph < 2; ph++) begin
         do_reset();
         for (int t = 0; t < 800; t++) begin
            logic [N-1:0]    v;
            logic [N*DW-1:0] d;
            for (int c = 0; c < N; c++) begin
               v[c]          = (ph == 0) ? ($urandom_range(7) == 0) : ($urandom_range(2) == 0);
               d[c*DW +: DW] = {$urandom, $urandom};
            end
            if ($urandom_range(299) == 0) do_reset();
            else step(v, d, $urandom_range(3) != 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
